// File: rtl/score_pkg.sv
// Shared types and helpers for the score keeper and its BCD counters.
package score_pkg;

  // FSM states of the score keeper
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_e;

  // Width of one BCD digit
  localparam int BCD_W = 4;

  // Width of the winner index; a single player still gets one bit
  function automatic int win_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Extracts player idx's packed BCD score from a score bus (up to 8 players x 4 digits)
  function automatic logic [15:0] player_slice(input logic [127:0] bus, input int idx,
                                               input int digits);
    logic [127:0] sh;
    logic [16:0]  mask;
    sh   = bus >> (idx * digits * BCD_W);
    mask = (17'h1 << (digits * BCD_W)) - 17'h1;
    return sh[15:0] & mask[15:0];
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter.sv
// Saturating multi-digit BCD up-counter with synchronous clear.
module bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      inc,
  output logic [DIGITS*BCD_W-1:0]   digits,
  output logic                      all_nines
);

  logic [DIGITS*BCD_W-1:0] digits_q, digits_d;
  logic                    carry;

  // Flag the all-nines value; the counter holds there instead of wrapping
  always_comb begin
    all_nines = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (digits_q[d*BCD_W +: BCD_W] != 4'd9) all_nines = 1'b0;
    end
  end

  // Ripple a +1 through the digits, 9 rolls to 0 and carries upward
  always_comb begin
    digits_d = digits_q;
    carry    = 1'b1;
    if (clear) begin
      digits_d = '0;
    end else if (inc && !all_nines) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (carry) begin
          if (digits_q[d*BCD_W +: BCD_W] == 4'd9) begin
            digits_d[d*BCD_W +: BCD_W] = 4'd0;
          end else begin
            digits_d[d*BCD_W +: BCD_W] = digits_q[d*BCD_W +: BCD_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Digit register
  always_ff @(posedge clock) begin
    digits_q <= digits_d;
  end

  assign digits = digits_q;

endmodule

// File: rtl/score_keeper.sv
// Scoreboard: edge-detected point flags, per-player BCD scores, serve hold and win latch.
//
// state | meaning
// PLAY  | accepting points; lowest-index rising flag is credited
// HOLD  | serve-hold interval after a point; rises ignored
// OVER  | winning score reached; scores frozen until clear/reset
module score_keeper
  import score_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter int          DIGITS      = 2,
  parameter int          WIN_SCORE   = 11,
  parameter logic [31:0] HOLD_COUNT  = 32'd49999999
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                clear_n,
  input  logic [NUM_PLAYERS-1:0]              point_in,
  output logic [NUM_PLAYERS*DIGITS*BCD_W-1:0] score_bcd,
  output logic [NUM_PLAYERS-1:0]              point_ack,
  output logic                                serve_hold,
  output logic                                game_over,
  output logic [win_w(NUM_PLAYERS)-1:0]       winner
);

  localparam int          WIN_W     = win_w(NUM_PLAYERS);
  localparam logic [15:0] WIN_VAL   = 16'(WIN_SCORE);
  // Hold timer counts down from HOLD_COUNT-1; terminal count 0 ends the hold
  localparam logic [31:0] HOLD_LOAD = (HOLD_COUNT == 32'd0) ? 32'd0 : HOLD_COUNT - 32'd1;

  state_e                 state_q, state_d;
  logic [31:0]            hold_cnt_q, hold_cnt_d;
  logic [NUM_PLAYERS-1:0] prev_q, prev_d;
  logic [NUM_PLAYERS-1:0] point_ack_q, point_ack_d;
  logic [WIN_W-1:0]       winner_q, winner_d;
  logic [15:0]            shadow_q [NUM_PLAYERS];
  logic [15:0]            shadow_d [NUM_PLAYERS];

  logic                   clr;
  logic                   found;
  logic [NUM_PLAYERS-1:0] rise;
  logic [NUM_PLAYERS-1:0] inc;
  logic [NUM_PLAYERS-1:0] all_nines;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign clr  = ~reset_n | ~clear_n;
  assign rise = point_in & ~prev_q;

  // Next-state: priority-credit the lowest rising player, then hold or finish
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    prev_d      = point_in;
    point_ack_d = '0;
    winner_d    = winner_q;
    shadow_d    = shadow_q;
    inc         = '0;
    found       = 1'b0;
    if (clr) begin
      state_d    = PLAY;
      hold_cnt_d = '0;
      winner_d   = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) shadow_d[i] = '0;
    end else begin
      case (state_q)
        PLAY: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (rise[i] && !found) begin
              found          = 1'b1;
              inc[i]         = ~all_nines[i];
              point_ack_d[i] = 1'b1;
              shadow_d[i]    = sat_inc(shadow_q[i]);
              if (WIN_SCORE != 0 && sat_inc(shadow_q[i]) == WIN_VAL) begin
                state_d  = OVER;
                winner_d = WIN_W'(i);
              end else if (HOLD_COUNT != 32'd0) begin
                state_d    = HOLD;
                hold_cnt_d = HOLD_LOAD;
              end
            end
          end
        end
        HOLD: begin
          if (hold_cnt_q == 32'd0) begin
            state_d = PLAY;
          end else begin
            hold_cnt_d = hold_cnt_q - 32'd1;
          end
        end
        OVER: ;
        default: state_d = PLAY;
      endcase
    end
  end

  // State and control registers; prev loads point_in even through reset
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    hold_cnt_q  <= hold_cnt_d;
    prev_q      <= prev_d;
    point_ack_q <= point_ack_d;
    winner_q    <= winner_d;
    shadow_q    <= shadow_d;
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_cnt
    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
      .clock     (clock),
      .clear     (clr),
      .inc       (inc[g]),
      .digits    (score_bcd[g*DIGITS*BCD_W +: DIGITS*BCD_W]),
      .all_nines (all_nines[g])
    );
  end

  assign point_ack  = point_ack_q;
  assign serve_hold = (state_q == HOLD);
  assign game_over  = (state_q == OVER);
  assign winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench: vector table on a WIN=3/HOLD=4 instance, plus
// hand sequences for BCD carry/saturation and reset during a long hold.
module tb_score_keeper;
  import score_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: WIN_SCORE=3, HOLD_COUNT=4
  logic        rst_a = 1'b0, clr_a = 1'b1;
  logic [1:0]  pt_a = 2'b00;
  logic [15:0] score_a;
  logic [1:0]  ack_a;
  logic        hold_a, over_a;
  logic [0:0]  win_a;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(3), .HOLD_COUNT(32'd4)) dut_a (
    .clock(clock), .reset_n(rst_a), .clear_n(clr_a), .point_in(pt_a),
    .score_bcd(score_a), .point_ack(ack_a), .serve_hold(hold_a),
    .game_over(over_a), .winner(win_a)
  );

  // Instance B: no win detection, no hold
  logic        rst_b = 1'b0, clr_b = 1'b1;
  logic [1:0]  pt_b = 2'b00;
  logic [15:0] score_b;
  logic [1:0]  ack_b;
  logic        hold_b, over_b;
  logic [0:0]  win_b;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .HOLD_COUNT(32'd0)) dut_b (
    .clock(clock), .reset_n(rst_b), .clear_n(clr_b), .point_in(pt_b),
    .score_bcd(score_b), .point_ack(ack_b), .serve_hold(hold_b),
    .game_over(over_b), .winner(win_b)
  );

  // Instance C: long hold
  logic        rst_c = 1'b0, clr_c = 1'b1;
  logic [1:0]  pt_c = 2'b00;
  logic [15:0] score_c;
  logic [1:0]  ack_c;
  logic        hold_c, over_c;
  logic [0:0]  win_c;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .HOLD_COUNT(32'd100)) dut_c (
    .clock(clock), .reset_n(rst_c), .clear_n(clr_c), .point_in(pt_c),
    .score_bcd(score_c), .point_ack(ack_c), .serve_hold(hold_c),
    .game_over(over_c), .winner(win_c)
  );

  typedef struct {
    int          reps;
    logic        rst_n;
    logic        clr_n;
    logic [1:0]  pt;
    logic [15:0] score;
    logic [1:0]  ack;
    logic        hold;
    logic        over;
    logic        win;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int   e;
    logic [15:0] exp_bcd;

    vecs = '{
      //  reps rst clr pt     score     ack    hold over win
      '{2,  0, 1, 2'b01, 16'h0000, 2'b00, 0, 0, 0},  // reset with flag held
      '{10, 1, 1, 2'b01, 16'h0000, 2'b00, 0, 0, 0},  // flag held through reset not scored
      '{1,  1, 1, 2'b00, 16'h0000, 2'b00, 0, 0, 0},
      '{1,  1, 1, 2'b10, 16'h0100, 2'b10, 1, 0, 0},  // player 1 scores
      '{3,  1, 1, 2'b10, 16'h0100, 2'b00, 1, 0, 0},  // hold cycles 2..4
      '{1,  1, 1, 2'b10, 16'h0100, 2'b00, 0, 0, 0},  // hold ends after 4 cycles
      '{1,  1, 1, 2'b00, 16'h0100, 2'b00, 0, 0, 0},
      '{1,  1, 1, 2'b11, 16'h0101, 2'b01, 1, 0, 0},  // simultaneous: player 0 wins priority
      '{1,  1, 1, 2'b00, 16'h0101, 2'b00, 1, 0, 0},
      '{1,  1, 1, 2'b10, 16'h0101, 2'b00, 1, 0, 0},  // rise inside hold ignored
      '{1,  1, 1, 2'b00, 16'h0101, 2'b00, 1, 0, 0},
      '{1,  1, 1, 2'b00, 16'h0101, 2'b00, 0, 0, 0},
      '{1,  1, 1, 2'b10, 16'h0201, 2'b10, 1, 0, 0},
      '{3,  1, 1, 2'b00, 16'h0201, 2'b00, 1, 0, 0},
      '{1,  1, 1, 2'b00, 16'h0201, 2'b00, 0, 0, 0},
      '{1,  1, 1, 2'b10, 16'h0301, 2'b10, 0, 1, 1},  // third point: game over, winner 1
      '{1,  1, 1, 2'b00, 16'h0301, 2'b00, 0, 1, 1},
      '{1,  1, 1, 2'b11, 16'h0301, 2'b00, 0, 1, 1},  // frozen
      '{1,  1, 1, 2'b00, 16'h0301, 2'b00, 0, 1, 1},
      '{1,  1, 1, 2'b01, 16'h0301, 2'b00, 0, 1, 1},
      '{1,  1, 0, 2'b00, 16'h0000, 2'b00, 0, 0, 0},  // clear
      '{1,  1, 1, 2'b01, 16'h0001, 2'b01, 1, 0, 0},  // back in play
      '{1,  0, 1, 2'b10, 16'h0000, 2'b00, 0, 0, 0},  // reset beats simultaneous rise
      '{1,  1, 1, 2'b10, 16'h0000, 2'b00, 0, 0, 0}
    };

    for (int v = 0; v < 24; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        rst_a = vecs[v].rst_n;
        clr_a = vecs[v].clr_n;
        pt_a  = vecs[v].pt;
        tick();
        check($sformatf("A[%0d.%0d] score", v, r), score_a, vecs[v].score);
        check($sformatf("A[%0d.%0d] ack", v, r), 16'(ack_a), 16'(vecs[v].ack));
        check($sformatf("A[%0d.%0d] hold", v, r), 16'(hold_a), 16'(vecs[v].hold));
        check($sformatf("A[%0d.%0d] over", v, r), 16'(over_a), 16'(vecs[v].over));
        check($sformatf("A[%0d.%0d] winner", v, r), 16'(win_a), 16'(vecs[v].win));
      end
    end
    check("A player1 slice", player_slice(128'(score_a), 1, 2), 16'h0000);

    // BCD carry and saturation on player 0
    rst_b = 1'b0;
    pt_b  = 2'b00;
    tick();
    rst_b = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      pt_b = 2'b01;
      tick();
      e       = (n > 99) ? 99 : n;
      exp_bcd = 16'((e / 10) * 16 + (e % 10));
      check($sformatf("B point %0d score", n), score_b, exp_bcd);
      check($sformatf("B point %0d ack", n), 16'(ack_b), 16'h0001);
      check($sformatf("B point %0d hold", n), 16'(hold_b), 16'h0000);
      check($sformatf("B point %0d over", n), 16'(over_b), 16'h0000);
      pt_b = 2'b00;
      tick();
      check($sformatf("B gap %0d ack", n), 16'(ack_b), 16'h0000);
    end
    check("B player0 slice", player_slice(128'(score_b), 0, 2), 16'h0099);

    // Reset in the middle of a 100-cycle hold
    rst_c = 1'b0;
    pt_c  = 2'b00;
    tick();
    rst_c = 1'b1;
    tick();
    pt_c = 2'b01;
    tick();
    check("C first score", score_c, 16'h0001);
    check("C first ack", 16'(ack_c), 16'h0001);
    check("C first hold", 16'(hold_c), 16'h0001);
    pt_c = 2'b00;
    for (int k = 2; k <= 50; k++) begin
      tick();
      check($sformatf("C hold cycle %0d", k), 16'(hold_c), 16'h0001);
    end
    rst_c = 1'b0;
    tick();
    check("C reset hold", 16'(hold_c), 16'h0000);
    check("C reset score", score_c, 16'h0000);
    rst_c = 1'b1;
    tick();
    check("C idle hold", 16'(hold_c), 16'h0000);
    pt_c = 2'b10;
    tick();
    check("C after reset score", score_c, 16'h0100);
    check("C after reset ack", 16'(ack_c), 16'h0002);
    check("C after reset hold", 16'(hold_c), 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
